// File: rtl/dcache_bus_pkg.sv
// Shared definitions for the data-cache to AXI bridge: FSM state encoding and
// the fixed AXI burst/size/response codes the bridge drives or checks.
package dcache_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/dcache_axi_bridge_if.sv
// AXI4 read/write channel bundle between the cache bridge (master) and the
// memory-side slave.
interface dcache_axi_bridge_if;

  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [31:0] rdata_m;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid_m;
  logic        rready;

  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata_m;
  logic [3:0]  wstrb;
  logic        wlast_m;
  logic        wvalid_m;
  logic        wready_m;

  logic [1:0]  bresp;
  logic        bvalid_m;
  logic        bready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata_m, rresp, rlast, rvalid_m,
    output rready,
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata_m, wstrb, wlast_m, wvalid_m,
    input  wready_m,
    input  bresp, bvalid_m,
    output bready
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata_m, rresp, rlast, rvalid_m,
    input  rready,
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata_m, wstrb, wlast_m, wvalid_m,
    output wready_m,
    output bresp, bvalid_m,
    input  bready
  );

endinterface

// File: rtl/dcache_axi_bridge.sv
// Data-cache line fill / write-back bridge onto AXI4, one burst outstanding.
// Define DCACHE_BRIDGE_WB_FIRST_EN to give write-back priority over miss.
module dcache_axi_bridge
  import dcache_bus_pkg::*;
#(
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        miss,
  input  logic [31:0] miss_addr,
  output logic [31:0] rdata,
  output logic        rvalid,

  input  logic        write_back,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic        wvalid,
  input  logic        wlast,
  output logic        wready,
  output logic        bvalid,

  output logic        bus_err,

  dcache_axi_bridge_if.master axi
);

  localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);
  localparam logic [3:0]  LAST_BEAT = 4'(LINE_WORDS - 1);

  state_e      state, state_nxt;
  logic [3:0]  beat_cnt, beat_nxt;
  logic [31:0] line_addr, addr_nxt;
  logic        err_nxt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      beat_cnt  <= 4'd0;
      line_addr <= 32'd0;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat_cnt  <= beat_nxt;
      line_addr <= addr_nxt;
      bus_err   <= err_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_nxt    = state;
    beat_nxt     = beat_cnt;
    addr_nxt     = line_addr;
    err_nxt      = bus_err;

    rdata        = 32'd0;
    rvalid       = 1'b0;
    wready       = 1'b0;
    bvalid       = 1'b0;

    axi.araddr   = 32'd0;
    axi.arlen    = 4'd0;
    axi.arsize   = 3'd0;
    axi.arburst  = 2'b00;
    axi.arvalid  = 1'b0;
    axi.rready   = 1'b0;
    axi.awaddr   = 32'd0;
    axi.awlen    = 4'd0;
    axi.awsize   = 3'd0;
    axi.awburst  = 2'b00;
    axi.awvalid  = 1'b0;
    axi.wdata_m  = 32'd0;
    axi.wstrb    = 4'h0;
    axi.wlast_m  = 1'b0;
    axi.wvalid_m = 1'b0;
    axi.bready   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        beat_nxt = 4'd0;
`ifdef DCACHE_BRIDGE_WB_FIRST_EN
        if (write_back) begin
          addr_nxt  = waddr & ~LINE_MASK;
          state_nxt = ST_AW;
        end else if (miss) begin
          addr_nxt  = miss_addr & ~LINE_MASK;
          state_nxt = ST_AR;
        end
`else
        if (miss) begin
          addr_nxt  = miss_addr & ~LINE_MASK;
          state_nxt = ST_AR;
        end else if (write_back) begin
          addr_nxt  = waddr & ~LINE_MASK;
          state_nxt = ST_AW;
        end
`endif
      end

      ST_AR: begin
        axi.arvalid = 1'b1;
        axi.araddr  = line_addr;
        axi.arlen   = LAST_BEAT;
        axi.arsize  = AXI_SIZE_WORD;
        axi.arburst = AXI_BURST_INCR;
        if (axi.arready) state_nxt = ST_R;
      end

      ST_R: begin
        axi.rready = 1'b1;
        rdata      = axi.rdata_m;
        rvalid     = axi.rvalid_m;
        if (axi.rvalid_m) begin
          if (axi.rresp != AXI_RESP_OKAY) err_nxt = 1'b1;
          if (axi.rlast) begin
            // A short or long burst still ends the fill; flag it as a bus fault.
            if (beat_cnt != LAST_BEAT) err_nxt = 1'b1;
            beat_nxt  = 4'd0;
            state_nxt = ST_IDLE;
          end else begin
            beat_nxt = beat_cnt + 4'd1;
          end
        end
      end

      ST_AW: begin
        axi.awvalid = 1'b1;
        axi.awaddr  = line_addr;
        axi.awlen   = LAST_BEAT;
        axi.awsize  = AXI_SIZE_WORD;
        axi.awburst = AXI_BURST_INCR;
        if (axi.awready) state_nxt = ST_W;
      end

      ST_W: begin
        axi.wvalid_m = wvalid;
        axi.wdata_m  = wdata;
        axi.wlast_m  = wlast;
        axi.wstrb    = 4'hF;
        wready       = axi.wready_m;
        if (wvalid && axi.wready_m) begin
          if (wlast) begin
            if (beat_cnt != LAST_BEAT) err_nxt = 1'b1;
            beat_nxt  = 4'd0;
            state_nxt = ST_B;
          end else begin
            beat_nxt = beat_cnt + 4'd1;
          end
        end
      end

      ST_B: begin
        axi.bready = 1'b1;
        if (axi.bvalid_m) begin
          // Leaving B on the same edge keeps the completion pulse one cycle wide.
          bvalid    = 1'b1;
          if (axi.bresp != AXI_RESP_OKAY) err_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Directed self-checking bench for dcache_axi_bridge: line fill, write-back,
// simultaneous requests, error responses, short burst and mid-burst reset.
module tb_dcache_axi_bridge;
  import dcache_bus_pkg::*;

  logic        clk;
  logic        resetn;
  logic        miss;
  logic [31:0] miss_addr;
  logic [31:0] rdata;
  logic        rvalid;
  logic        write_back;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wlast;
  logic        wready;
  logic        bvalid;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  dcache_axi_bridge_if axi ();

  dcache_axi_bridge #(.LINE_WORDS(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .miss       (miss),
    .miss_addr  (miss_addr),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .write_back (write_back),
    .waddr      (waddr),
    .wdata      (wdata),
    .wvalid     (wvalid),
    .wlast      (wlast),
    .wready     (wready),
    .bvalid     (bvalid),
    .bus_err    (bus_err),
    .axi        (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, 32'(dut.state), 32'(ST_IDLE));
    check({tag, "_arvalid"}, 32'(axi.arvalid), 32'd0);
    check({tag, "_awvalid"}, 32'(axi.awvalid), 32'd0);
    check({tag, "_rready"}, 32'(axi.rready), 32'd0);
    check({tag, "_bready"}, 32'(axi.bready), 32'd0);
  endtask

  // Entered with the bridge already in AR; holds arready low for `waits` cycles.
  task automatic ar_phase(input logic [31:0] exp_addr, input int waits);
    for (int i = 0; i < waits; i++) begin
      check("ar_wait_valid", 32'(axi.arvalid), 32'd1);
      check("ar_wait_addr", axi.araddr, exp_addr);
      tick();
    end
    axi.arready = 1'b1;
    #1;
    check("arvalid", 32'(axi.arvalid), 32'd1);
    check("araddr", axi.araddr, exp_addr);
    check("arlen", 32'(axi.arlen), 32'd7);
    check("arsize", 32'(axi.arsize), 32'd2);
    check("arburst", 32'(axi.arburst), 32'd1);
    tick();
    axi.arready = 1'b0;
  endtask

  // Delivers beats 0..last_beat with rlast on last_beat.
  task automatic r_phase(input int last_beat, input logic [31:0] d0);
    for (int i = 0; i <= last_beat; i++) begin
      axi.rvalid_m = 1'b1;
      axi.rdata_m  = d0 + 32'(i);
      axi.rlast    = (i == last_beat);
      axi.rresp    = 2'b00;
      #1;
      check("r_rready", 32'(axi.rready), 32'd1);
      check("r_rvalid", 32'(rvalid), 32'd1);
      check("r_rdata", rdata, d0 + 32'(i));
      tick();
    end
    axi.rvalid_m = 1'b0;
    axi.rlast    = 1'b0;
    #1;
    check("r_done_state", 32'(dut.state), 32'(ST_IDLE));
    check("r_done_rvalid", 32'(rvalid), 32'd0);
  endtask

  // Entered in AW; wready_m is forced high to prove wready stays low outside W.
  task automatic aw_phase(input logic [31:0] exp_addr, input int waits);
    axi.wready_m = 1'b1;
    wvalid = 1'b1;
    for (int i = 0; i < waits; i++) begin
      #1;
      check("aw_wait_valid", 32'(axi.awvalid), 32'd1);
      check("aw_wready_low", 32'(wready), 32'd0);
      check("aw_wvalid_m_low", 32'(axi.wvalid_m), 32'd0);
      tick();
    end
    axi.awready = 1'b1;
    #1;
    check("awvalid", 32'(axi.awvalid), 32'd1);
    check("awaddr", axi.awaddr, exp_addr);
    check("awlen", 32'(axi.awlen), 32'd7);
    check("awsize", 32'(axi.awsize), 32'd2);
    check("awburst", 32'(axi.awburst), 32'd1);
    tick();
    axi.awready  = 1'b0;
    axi.wready_m = 1'b0;
    wvalid       = 1'b0;
  endtask

  // Eight beats with wready_m toggling 1/0; bounded by a cycle budget.
  task automatic w_phase(input logic [31:0] d0);
    int beat = 0;
    int hs = 0;
    logic rdy = 1'b1;
    for (int cyc = 0; cyc < 32 && beat < 8; cyc++) begin
      wvalid = 1'b1;
      wdata  = d0 + 32'(beat);
      wlast  = (beat == 7);
      axi.wready_m = rdy;
      #1;
      check("w_wvalid_m", 32'(axi.wvalid_m), 32'd1);
      check("w_wdata_m", axi.wdata_m, d0 + 32'(beat));
      check("w_wstrb", 32'(axi.wstrb), 32'hF);
      check("w_wlast_m", 32'(axi.wlast_m), 32'(beat == 7));
      check("w_wready", 32'(wready), 32'(rdy));
      if (rdy) begin
        beat++;
        hs++;
      end
      rdy = ~rdy;
      tick();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    axi.wready_m = 1'b0;
    #1;
    check("w_handshakes", 32'(hs), 32'd8);
    check("w_to_b_bready", 32'(axi.bready), 32'd1);
  endtask

  task automatic b_phase(input logic [1:0] resp, input int delay);
    for (int i = 0; i < delay; i++) begin
      check("b_wait_bvalid", 32'(bvalid), 32'd0);
      tick();
    end
    axi.bvalid_m = 1'b1;
    axi.bresp    = resp;
    #1;
    check("b_bvalid", 32'(bvalid), 32'd1);
    tick();
    axi.bvalid_m = 1'b0;
    axi.bresp    = 2'b00;
    #1;
    check("b_pulse_end", 32'(bvalid), 32'd0);
    check("b_done_state", 32'(dut.state), 32'(ST_IDLE));
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    resetn = 1'b0;
    miss = 1'b0; miss_addr = 32'd0;
    write_back = 1'b0; waddr = 32'd0;
    wdata = 32'd0; wvalid = 1'b0; wlast = 1'b0;
    axi.arready = 1'b0; axi.awready = 1'b0;
    axi.rdata_m = 32'd0; axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rvalid_m = 1'b0;
    axi.wready_m = 1'b0; axi.bresp = 2'b00; axi.bvalid_m = 1'b0;
    tick();
    tick();
    #1;
    check_idle("rst");
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_wvalid_m", 32'(axi.wvalid_m), 32'd0);
    check("rst_araddr", axi.araddr, 32'd0);
    resetn = 1'b1;
    tick();

    // Line fill: unaligned miss address, arready after two cycles, eight beats.
    miss = 1'b1; miss_addr = 32'h1000_0014;
    tick();
    miss = 1'b0;
    ar_phase(32'h1000_0000, 2);
    r_phase(7, 32'h0000_00A0);
    check("fill_bus_err", 32'(bus_err), 32'd0);

    // Write-back with toggling wready_m and a single completion pulse.
    write_back = 1'b1; waddr = 32'h2000_0020;
    tick();
    write_back = 1'b0;
    aw_phase(32'h2000_0020, 1);
    w_phase(32'h0000_00B0);
    b_phase(2'b00, 2);
    check("wb_bus_err", 32'(bus_err), 32'd0);

    // Simultaneous requests; the loser is held and served after the winner.
    miss = 1'b1; miss_addr = 32'h3000_004C;
    write_back = 1'b1; waddr = 32'h4000_0090;
    tick();
`ifdef DCACHE_BRIDGE_WB_FIRST_EN
    check("both_awvalid_first", 32'(axi.awvalid), 32'd1);
    check("both_arvalid_first", 32'(axi.arvalid), 32'd0);
    write_back = 1'b0;
    aw_phase(32'h4000_0080, 0);
    w_phase(32'h0000_00C0);
    b_phase(2'b00, 0);
    check("both_no_bypass", 32'(axi.arvalid), 32'd0);
    tick();
    miss = 1'b0;
    ar_phase(32'h3000_0040, 0);
    r_phase(7, 32'h0000_00D0);
`else
    check("both_arvalid_first", 32'(axi.arvalid), 32'd1);
    check("both_awvalid_first", 32'(axi.awvalid), 32'd0);
    miss = 1'b0;
    ar_phase(32'h3000_0040, 0);
    r_phase(7, 32'h0000_00D0);
    check("both_no_bypass", 32'(axi.awvalid), 32'd0);
    tick();
    write_back = 1'b0;
    aw_phase(32'h4000_0080, 0);
    w_phase(32'h0000_00C0);
    b_phase(2'b00, 0);
`endif

    // SLVERR on the write response is sticky across a clean read.
    write_back = 1'b1; waddr = 32'h5000_0000;
    tick();
    write_back = 1'b0;
    aw_phase(32'h5000_0000, 0);
    w_phase(32'h0000_0010);
    b_phase(2'b10, 1);
    check("bresp_err_set", 32'(bus_err), 32'd1);
    miss = 1'b1; miss_addr = 32'h6000_0000;
    tick();
    miss = 1'b0;
    ar_phase(32'h6000_0000, 1);
    r_phase(7, 32'h0000_0020);
    check("err_sticky", 32'(bus_err), 32'd1);
    apply_reset();
    check("err_cleared_by_reset", 32'(bus_err), 32'd0);

    // Early rlast on beat 5 ends the fill and flags an error.
    miss = 1'b1; miss_addr = 32'h7000_0020;
    tick();
    miss = 1'b0;
    ar_phase(32'h7000_0020, 0);
    r_phase(5, 32'h0000_0030);
    check("short_burst_err", 32'(bus_err), 32'd1);
    apply_reset();

    // Reset asserted during beat 3 drops everything in the same cycle.
    miss = 1'b1; miss_addr = 32'h8000_0000;
    tick();
    miss = 1'b0;
    ar_phase(32'h8000_0000, 0);
    for (int i = 0; i < 3; i++) begin
      axi.rvalid_m = 1'b1;
      axi.rdata_m  = 32'h40 + 32'(i);
      #1;
      check("pre_rst_rdata", rdata, 32'h40 + 32'(i));
      tick();
    end
    axi.rdata_m = 32'h43;
    #1;
    check("beat3_rvalid", 32'(rvalid), 32'd1);
    resetn = 1'b0;
    #1;
    check("midrst_rvalid", 32'(rvalid), 32'd0);
    check_idle("midrst");
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_rvalid", 32'(rvalid), 32'd0);
    end
    axi.rvalid_m = 1'b0;
    check("post_rst_bus_err", 32'(bus_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
